// File: rtl/char_5_axi_lite_slave_if.sv
// AXI4-Lite bus bundle for the char_5 register file.
// The master modport is the interconnect side and the slave modport is the register file side.
interface char_5_axi_lite_slave_if #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
);
  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR;
  logic [2:0]                        S_AXI_AWPROT;
  logic                              S_AXI_AWVALID;
  logic                              S_AXI_AWREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA;
  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB;
  logic                              S_AXI_WVALID;
  logic                              S_AXI_WREADY;
  logic [1:0]                        S_AXI_BRESP;
  logic                              S_AXI_BVALID;
  logic                              S_AXI_BREADY;
  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR;
  logic [2:0]                        S_AXI_ARPROT;
  logic                              S_AXI_ARVALID;
  logic                              S_AXI_ARREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA;
  logic [1:0]                        S_AXI_RRESP;
  logic                              S_AXI_RVALID;
  logic                              S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output S_AXI_RREADY
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  S_AXI_RREADY
  );
endinterface

// File: rtl/char_5_axi_lite_slave.sv
// char_5 AXI4-Lite register file: four 32-bit RW registers with a one-cycle write pulse per register.
// AW and W are collected independently, committed in one cycle, then answered with an OKAY response.
// Reads are served from a separate two-state path that never waits on the write path.
module char_5_axi_lite_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                  S_AXI_ACLK,
  input  logic                  S_AXI_ARESETN,
  char_5_axi_lite_slave_if.slave s_axi,
  output logic [127:0]          regs_o,
  output logic [3:0]            reg_wr_pulse_o
);

  localparam logic [1:0] W_ACCEPT = 2'd0;
  localparam logic [1:0] W_COMMIT = 2'd1;
  localparam logic [1:0] W_RESP   = 2'd2;
  localparam logic [0:0] R_IDLE   = 1'b0;
  localparam logic [0:0] R_VALID  = 1'b1;

  // Byte-lane merge: lanes with a strobe take new data, the rest keep the old value.
  function automatic logic [31:0] f_strb_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                               input logic [3:0] strb);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
      else         res[8*b +: 8] = old_v[8*b +: 8];
    end
    return res;
  endfunction

  logic [C_S_AXI_DATA_WIDTH-1:0] r_regs [4];

  logic [1:0]  r_wstate, w_wstate_nxt;
  logic        r_aw_held, r_w_held, w_aw_held_nxt, w_w_held_nxt;
  logic [1:0]  r_awidx;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_awready, r_wready, r_bvalid;
  logic [3:0]  r_pulse;

  logic [0:0]  r_rstate, w_rstate_nxt;
  logic        r_arready, r_rvalid;
  logic [31:0] r_rdata;

  logic [C_S_AXI_ADDR_WIDTH-1:0] w_awaddr, w_araddr;
  logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
  logic w_unused;

  assign w_awaddr = s_axi.S_AXI_AWADDR;
  assign w_araddr = s_axi.S_AXI_ARADDR;
  assign w_aw_hs  = s_axi.S_AXI_AWVALID & r_awready;
  assign w_w_hs   = s_axi.S_AXI_WVALID  & r_wready;
  assign w_b_hs   = r_bvalid & s_axi.S_AXI_BREADY;
  assign w_ar_hs  = s_axi.S_AXI_ARVALID & r_arready;
  assign w_r_hs   = r_rvalid & s_axi.S_AXI_RREADY;
  // Protection bits and byte-offset address bits carry no meaning for this block.
  assign w_unused = &{1'b0, s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT, w_awaddr[1:0], w_araddr[1:0]};

  assign s_axi.S_AXI_AWREADY = r_awready;
  assign s_axi.S_AXI_WREADY  = r_wready;
  assign s_axi.S_AXI_BVALID  = r_bvalid;
  assign s_axi.S_AXI_BRESP   = 2'b00;
  assign s_axi.S_AXI_ARREADY = r_arready;
  assign s_axi.S_AXI_RVALID  = r_rvalid;
  assign s_axi.S_AXI_RDATA   = r_rdata;
  assign s_axi.S_AXI_RRESP   = 2'b00;
  assign regs_o         = {r_regs[3], r_regs[2], r_regs[1], r_regs[0]};
  assign reg_wr_pulse_o = r_pulse;

  // Write path next state: gather AW/W in any order, commit once both are held, wait for B.
  always_comb begin
    w_wstate_nxt  = r_wstate;
    w_aw_held_nxt = r_aw_held;
    w_w_held_nxt  = r_w_held;
    case (r_wstate)
      W_ACCEPT: begin
        if (w_aw_hs) w_aw_held_nxt = 1'b1;
        else         w_aw_held_nxt = r_aw_held;
        if (w_w_hs)  w_w_held_nxt = 1'b1;
        else         w_w_held_nxt = r_w_held;
        if (r_aw_held && r_w_held) w_wstate_nxt = W_COMMIT;
        else                       w_wstate_nxt = W_ACCEPT;
      end
      W_COMMIT: w_wstate_nxt = W_RESP;
      W_RESP: begin
        if (w_b_hs) begin
          w_wstate_nxt  = W_ACCEPT;
          w_aw_held_nxt = 1'b0;
          w_w_held_nxt  = 1'b0;
        end else begin
          w_wstate_nxt  = W_RESP;
        end
      end
      default: begin
        w_wstate_nxt  = W_ACCEPT;
        w_aw_held_nxt = 1'b0;
        w_w_held_nxt  = 1'b0;
      end
    endcase
  end

  // Write path control flops; READYs, BVALID and the pulse are registered from the next state.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_wstate  <= W_ACCEPT;
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_pulse   <= 4'b0000;
    end else begin
      r_wstate  <= w_wstate_nxt;
      r_aw_held <= w_aw_held_nxt;
      r_w_held  <= w_w_held_nxt;
      r_awready <= (w_wstate_nxt == W_ACCEPT) && !w_aw_held_nxt;
      r_wready  <= (w_wstate_nxt == W_ACCEPT) && !w_w_held_nxt;
      r_bvalid  <= (w_wstate_nxt == W_RESP);
      r_pulse   <= (w_wstate_nxt == W_COMMIT) ? (4'b0001 << r_awidx) : 4'b0000;
    end
  end

  // Capture the write address index and data/strobes on their respective handshakes.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_awidx <= 2'b00;
      r_wdata <= 32'h0000_0000;
      r_wstrb <= 4'b0000;
    end else begin
      if (w_aw_hs) r_awidx <= w_awaddr[3:2];
      if (w_w_hs) begin
        r_wdata <= s_axi.S_AXI_WDATA;
        r_wstrb <= s_axi.S_AXI_WSTRB;
      end
    end
  end

  // Register file: the held write lands at the end of the commit cycle.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      for (int i = 0; i < 4; i++) r_regs[i] <= 32'h0000_0000;
    end else if (r_wstate == W_COMMIT) begin
      r_regs[r_awidx] <= f_strb_merge(r_regs[r_awidx], r_wdata, r_wstrb);
    end
  end

  // Read path next state: one address accepted, data held until taken.
  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE: begin
        if (w_ar_hs) w_rstate_nxt = R_VALID;
        else         w_rstate_nxt = R_IDLE;
      end
      R_VALID: begin
        if (w_r_hs) w_rstate_nxt = R_IDLE;
        else        w_rstate_nxt = R_VALID;
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  // Read path flops; RDATA samples the register before any same-cycle commit lands.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= 32'h0000_0000;
    end else begin
      r_rstate  <= w_rstate_nxt;
      r_arready <= (w_rstate_nxt == R_IDLE);
      r_rvalid  <= (w_rstate_nxt == R_VALID);
      if (w_ar_hs) r_rdata <= r_regs[w_araddr[3:2]];
    end
  end

endmodule

// File: tb/tb_char_5_axi_lite_slave.sv
// Self-checking bench for char_5_axi_lite_slave: a reference register model and a read-data queue
// supply every expected value; each scenario task checks its own results inline.
module tb_char_5_axi_lite_slave;

  logic         clk;
  logic         rst_n;
  logic [127:0] regs;
  logic [3:0]   pulse;

  int n_pass;
  int n_total;

  logic [31:0] model [4];
  logic [31:0] exp_q [$];

  char_5_axi_lite_slave_if #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) axi ();

  char_5_axi_lite_slave #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .s_axi         (axi),
    .regs_o        (regs),
    .reg_wr_pulse_o(pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] lane_merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] m;
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (d & m) | (o & ~m);
  endfunction

  // AW and W together; model updated once both handshakes are seen.
  task automatic axi_write_hs(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
    bit aw_done = 1'b0, w_done = 1'b0, a, w;
    int cnt = 0;
    axi.S_AXI_AWADDR = addr; axi.S_AXI_WDATA = data; axi.S_AXI_WSTRB = strb;
    axi.S_AXI_AWVALID = 1'b1; axi.S_AXI_WVALID = 1'b1;
    while (!(aw_done && w_done) && cnt < 50) begin
      a = axi.S_AXI_AWVALID && axi.S_AXI_AWREADY;
      w = axi.S_AXI_WVALID && axi.S_AXI_WREADY;
      @(posedge clk); #1; cnt++;
      if (a) begin aw_done = 1'b1; axi.S_AXI_AWVALID = 1'b0; end
      if (w) begin w_done = 1'b1; axi.S_AXI_WVALID = 1'b0; end
    end
    axi.S_AXI_AWVALID = 1'b0; axi.S_AXI_WVALID = 1'b0;
    n_total++;
    if (!(aw_done && w_done)) $display("FAIL write_handshake: aw_done=%0d w_done=%0d required 1 1", aw_done, w_done);
    else n_pass++;
    model[addr[3:2]] = lane_merge(model[addr[3:2]], data, strb);
  endtask

  task automatic wait_b();
    int cnt = 0;
    axi.S_AXI_BREADY = 1'b1;
    while (!axi.S_AXI_BVALID && cnt < 50) begin @(posedge clk); #1; cnt++; end
    n_total++;
    if (axi.S_AXI_BVALID !== 1'b1 || axi.S_AXI_BRESP !== 2'b00)
      $display("FAIL b_response: bvalid=%b bresp=%b required 1 00", axi.S_AXI_BVALID, axi.S_AXI_BRESP);
    else n_pass++;
    @(posedge clk); #1;
    axi.S_AXI_BREADY = 1'b0;
  endtask

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
    axi_write_hs(addr, data, strb);
    wait_b();
  endtask

  task automatic read_issue(input logic [3:0] addr);
    int cnt = 0;
    axi.S_AXI_ARADDR = addr; axi.S_AXI_ARVALID = 1'b1;
    while (!axi.S_AXI_ARREADY && cnt < 50) begin @(posedge clk); #1; cnt++; end
    n_total++;
    if (axi.S_AXI_ARREADY !== 1'b1) $display("FAIL ar_handshake: arready=%b required 1", axi.S_AXI_ARREADY);
    else n_pass++;
    @(posedge clk); #1;
    axi.S_AXI_ARVALID = 1'b0;
    exp_q.push_back(model[addr[3:2]]);
  endtask

  task automatic read_collect();
    int cnt = 0;
    logic [31:0] e;
    axi.S_AXI_RREADY = 1'b1;
    while (!axi.S_AXI_RVALID && cnt < 50) begin @(posedge clk); #1; cnt++; end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
    n_total++;
    if (axi.S_AXI_RVALID !== 1'b1 || axi.S_AXI_RDATA !== e || axi.S_AXI_RRESP !== 2'b00)
      $display("FAIL read_data: rvalid=%b rdata=%h rresp=%b required 1 %h 00",
               axi.S_AXI_RVALID, axi.S_AXI_RDATA, axi.S_AXI_RRESP, e);
    else n_pass++;
    @(posedge clk); #1;
    axi.S_AXI_RREADY = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if ({axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_ARREADY, axi.S_AXI_BVALID, axi.S_AXI_RVALID} !== 5'b00000 ||
        regs !== 128'd0 || pulse !== 4'b0000 || axi.S_AXI_RDATA !== 32'd0)
      $display("FAIL reset_state: ready/valid=%b regs=%h pulse=%b rdata=%h required all zero",
               {axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_ARREADY, axi.S_AXI_BVALID, axi.S_AXI_RVALID},
               regs, pulse, axi.S_AXI_RDATA);
    else n_pass++;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_total++;
    if ({axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_ARREADY} !== 3'b111)
      $display("FAIL ready_after_reset: readys=%b required 111", {axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_ARREADY});
    else n_pass++;
  endtask

  task automatic test_write_read();
    for (int i = 0; i < 4; i++) axi_write(4'(4 * i), 32'(i + 1), 4'hF);
    for (int i = 0; i < 4; i++) begin
      read_issue(4'(4 * i));
      read_collect();
    end
    n_total++;
    if (regs !== {32'd4, 32'd3, 32'd2, 32'd1}) $display("FAIL regs_out: regs=%h required 4,3,2,1", regs);
    else n_pass++;
  endtask

  task automatic test_w_before_aw();
    int cnt = 0;
    axi.S_AXI_WDATA = 32'hDEAD_BEEF; axi.S_AXI_WSTRB = 4'hF; axi.S_AXI_WVALID = 1'b1;
    while (!axi.S_AXI_WREADY && cnt < 50) begin @(posedge clk); #1; cnt++; end
    @(posedge clk); #1;
    axi.S_AXI_WVALID = 1'b0;
    repeat (2) begin
      n_total++;
      if (pulse !== 4'b0000 || axi.S_AXI_BVALID !== 1'b0 || axi.S_AXI_WREADY !== 1'b0)
        $display("FAIL w_only_wait: pulse=%b bvalid=%b wready=%b required 0000 0 0", pulse, axi.S_AXI_BVALID, axi.S_AXI_WREADY);
      else n_pass++;
      @(posedge clk); #1;
    end
    axi.S_AXI_AWADDR = 4'h8; axi.S_AXI_AWVALID = 1'b1;
    n_total++;
    if (axi.S_AXI_AWREADY !== 1'b1) $display("FAIL awready_late: awready=%b required 1", axi.S_AXI_AWREADY);
    else n_pass++;
    @(posedge clk); #1;
    axi.S_AXI_AWVALID = 1'b0;
    model[2] = 32'hDEAD_BEEF;
    n_total++;
    if (pulse !== 4'b0000 || axi.S_AXI_BVALID !== 1'b0)
      $display("FAIL commit_cycle0: pulse=%b bvalid=%b required 0000 0", pulse, axi.S_AXI_BVALID);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (pulse !== 4'b0100 || axi.S_AXI_BVALID !== 1'b0)
      $display("FAIL commit_pulse: pulse=%b bvalid=%b required 0100 0", pulse, axi.S_AXI_BVALID);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (pulse !== 4'b0000 || axi.S_AXI_BVALID !== 1'b1 || regs[95:64] !== 32'hDEAD_BEEF)
      $display("FAIL bvalid_timing: pulse=%b bvalid=%b reg2=%h required 0000 1 deadbeef", pulse, axi.S_AXI_BVALID, regs[95:64]);
    else n_pass++;
    wait_b();
  endtask

  task automatic test_strobe();
    axi_write(4'h4, 32'h1122_3344, 4'hF);
    axi_write(4'h4, 32'hAABB_CCDD, 4'b0010);
    n_total++;
    if (regs[63:32] !== 32'h1122_CC44) $display("FAIL strobe_merge: reg1=%h required 1122cc44", regs[63:32]);
    else n_pass++;
    axi_write(4'h0, 32'hFFFF_FFFF, 4'b0000);
    read_issue(4'h6);
    read_collect();
    read_issue(4'h3);
    read_collect();
  endtask

  task automatic test_b_backpressure();
    int cnt = 0;
    axi_write_hs(4'hC, 32'hA5A5_A5A5, 4'hF);
    while (!axi.S_AXI_BVALID && cnt < 50) begin @(posedge clk); #1; cnt++; end
    axi.S_AXI_AWADDR = 4'h4; axi.S_AXI_WDATA = 32'h5A5A_5A5A; axi.S_AXI_WSTRB = 4'hF;
    axi.S_AXI_AWVALID = 1'b1; axi.S_AXI_WVALID = 1'b1;
    repeat (5) begin
      n_total++;
      if ({axi.S_AXI_BVALID, axi.S_AXI_AWREADY, axi.S_AXI_WREADY} !== 3'b100 || pulse !== 4'b0000)
        $display("FAIL b_hold: bvalid/awready/wready=%b pulse=%b required 100 0000",
                 {axi.S_AXI_BVALID, axi.S_AXI_AWREADY, axi.S_AXI_WREADY}, pulse);
      else n_pass++;
      @(posedge clk); #1;
    end
    wait_b();
    n_total++;
    if (regs[63:32] !== model[1]) $display("FAIL write_blocked: reg1=%h required %h", regs[63:32], model[1]);
    else n_pass++;
    axi_write(4'h4, 32'h5A5A_5A5A, 4'hF);
    read_issue(4'h4);
    read_collect();
  endtask

  task automatic test_r_backpressure();
    int cnt = 0;
    axi_write(4'hC, 32'hCAFE_F00D, 4'hF);
    read_issue(4'hC);
    while (!axi.S_AXI_RVALID && cnt < 50) begin @(posedge clk); #1; cnt++; end
    repeat (4) begin
      n_total++;
      if (axi.S_AXI_RVALID !== 1'b1 || axi.S_AXI_RDATA !== 32'hCAFE_F00D || axi.S_AXI_ARREADY !== 1'b0)
        $display("FAIL r_hold: rvalid=%b rdata=%h arready=%b required 1 cafef00d 0",
                 axi.S_AXI_RVALID, axi.S_AXI_RDATA, axi.S_AXI_ARREADY);
      else n_pass++;
      @(posedge clk); #1;
    end
    read_collect();
    n_total++;
    if (axi.S_AXI_ARREADY !== 1'b1) $display("FAIL arready_return: arready=%b required 1", axi.S_AXI_ARREADY);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int cnt = 0;
    axi.S_AXI_AWADDR = 4'h8; axi.S_AXI_AWVALID = 1'b1;
    while (!axi.S_AXI_AWREADY && cnt < 50) begin @(posedge clk); #1; cnt++; end
    @(posedge clk); #1;
    axi.S_AXI_AWVALID = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if ({axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_ARREADY, axi.S_AXI_BVALID} !== 4'b0000 || regs !== 128'd0)
      $display("FAIL mid_reset: readys/bvalid=%b regs=%h required 0000 zero",
               {axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_ARREADY, axi.S_AXI_BVALID}, regs);
    else n_pass++;
    for (int i = 0; i < 4; i++) model[i] = 32'd0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      n_total++;
      if (axi.S_AXI_BVALID !== 1'b0 || pulse !== 4'b0000)
        $display("FAIL no_b_after_reset: bvalid=%b pulse=%b required 0 0000", axi.S_AXI_BVALID, pulse);
      else n_pass++;
    end
    axi_write(4'h8, 32'h0BAD_CAFE, 4'hF);
    read_issue(4'h8);
    read_collect();
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    for (int i = 0; i < 4; i++) model[i] = 32'd0;
    rst_n = 1'b0;
    axi.S_AXI_AWADDR = 4'h0; axi.S_AXI_AWPROT = 3'b000; axi.S_AXI_AWVALID = 1'b0;
    axi.S_AXI_WDATA = 32'd0; axi.S_AXI_WSTRB = 4'h0; axi.S_AXI_WVALID = 1'b0;
    axi.S_AXI_BREADY = 1'b0;
    axi.S_AXI_ARADDR = 4'h0; axi.S_AXI_ARPROT = 3'b000; axi.S_AXI_ARVALID = 1'b0;
    axi.S_AXI_RREADY = 1'b0;
    test_reset();
    test_write_read();
    test_w_before_aw();
    test_strobe();
    test_b_backpressure();
    test_r_backpressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
